qspi_flash_okuyucu: RTL and testbench

Memory-mapped QSPI flash read controller that slaves to the processor's `iomem` bus and serves 32-bit reads from an external quad-SPI NOR flash. It turns each accepted `iomem` read into a Fast Read Quad Output (0x6B) transaction. Data returns little-endian on `iomem_rdata` with a one-cycle `iomem_ready` pulse. It sits directly downstream of the processor's `iomem` port, so L1 cache refills from the `iomem` bus are served from flash.

---
 rtl/qspi_flash_okuyucu_pkg.sv | 32 +++
 rtl/qspi_flash_okuyucu_if.sv | 20 ++
 rtl/qspi_flash_okuyucu_sck.sv | 38 +++
 rtl/qspi_flash_okuyucu.sv | 132 +++++++++++++
 tb/tb_qspi_flash_okuyucu.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/qspi_flash_okuyucu_pkg.sv
// Shared constants and types for the QSPI flash read controller.
package qspi_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMD   = 3'd1,
    S_ADDR  = 3'd2,
    S_DUMMY = 3'd3,
    S_DATA  = 3'd4,
    S_DONE  = 3'd5,
    S_GAP   = 3'd6
  } qspi_state_e;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CMD   = 3'd1;
  localparam logic [2:0] ST_ADDR  = 3'd2;
  localparam logic [2:0] ST_DUMMY = 3'd3;
  localparam logic [2:0] ST_DATA  = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;
  localparam logic [2:0] ST_GAP   = 3'd6;

  localparam logic [7:0] QSPI_CMD_QOR = 8'h6B;
  localparam int CMD_BITS     = 8;
  localparam int ADDR_BITS    = 24;
  localparam int DATA_NIBBLES = 8;

  // Flash streams byte 0 first; the bus wants byte 0 in the low lane.
  function automatic logic [31:0] bswap32(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

endpackage

// File: rtl/qspi_flash_okuyucu_if.sv
// iomem bus bundle. valid is held by the master until a one-cycle ready
// pulse; rdata is meaningful only during that ready cycle.
interface qspi_flash_okuyucu_if;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;

  modport master (
    output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    input  iomem_ready, iomem_rdata
  );

  modport slave (
    input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    output iomem_ready, iomem_rdata
  );
endinterface

// File: rtl/qspi_flash_okuyucu_sck.sv
// SPI mode-0 clock generator: half-period of CLK_DIV clk cycles, with strobes
// that mark the clk edge on which sck rises or falls.
module qspi_sck_bolucu #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic sck,
  output logic rise,
  output logic fall
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] TOP = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap = en && (cnt == TOP);
  assign rise = wrap && !sck;
  assign fall = wrap && sck;

  // Disabling parks sck low and restarts the half-period count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (wrap) begin
      cnt <= '0;
      sck <= ~sck;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/qspi_flash_okuyucu.sv
// iomem slave that serves 32-bit reads from QSPI NOR flash using the
// Fast Read Quad Output (0x6B) command; writes are acknowledged and dropped.
module qspi_flash_okuyucu
  import qspi_pkg::*;
#(
  parameter int CLK_DIV   = 1,
  parameter int DUMMY_CYC = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  qspi_flash_okuyucu_if.slave   bus,
  output logic                  spi_cs_o,
  output logic                  spi_sck_o,
  output logic [3:0]            qspi_io_o,
  output logic [3:0]            qspi_io_oe,
  input  logic [3:0]            qspi_io_i,
  output qspi_state_e           state_dbg
);
  localparam logic [15:0] GAP_LAST = 16'(2 * CLK_DIV - 1);

  logic [2:0]  state;
  logic [7:0]  bit_cnt;
  logic [7:0]  phase_last;
  logic [15:0] gap_cnt;
  logic [31:0] sh;
  logic [31:0] nib;
  logic        cs;
  logic        ready;
  logic [31:0] rdata;
  logic        sck_en, sck, sck_rise, sck_fall;
  logic        drive_io0;
  logic        unused_bus_bits;

  assign unused_bus_bits = ^{bus.iomem_wdata, bus.iomem_addr[31:24], bus.iomem_addr[1:0]};

  assign sck_en = (state == ST_CMD) || (state == ST_ADDR) ||
                  (state == ST_DUMMY) || (state == ST_DATA);

  qspi_sck_bolucu #(.CLK_DIV(CLK_DIV)) u_sck (
    .clk   (clk),
    .reset (reset),
    .en    (sck_en),
    .sck   (sck),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  always_comb begin
    phase_last = 8'd0;
    case (state)
      ST_CMD:   phase_last = 8'(CMD_BITS - 1);
      ST_ADDR:  phase_last = 8'(ADDR_BITS - 1);
      ST_DUMMY: phase_last = 8'(DUMMY_CYC - 1);
      ST_DATA:  phase_last = 8'(DATA_NIBBLES - 1);
      default:  phase_last = 8'd0;
    endcase
  end

  // ready and rdata default low so both are one-cycle pulses out of DONE entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      gap_cnt <= '0;
      sh      <= '0;
      nib     <= '0;
      cs      <= 1'b1;
      ready   <= 1'b0;
      rdata   <= '0;
    end else begin
      ready <= 1'b0;
      rdata <= '0;
      case (state)
        ST_IDLE: begin
          if (bus.iomem_valid) begin
            if (bus.iomem_wstrb != 4'b0000) begin
              state <= ST_DONE;
              ready <= 1'b1;
            end else begin
              state   <= ST_CMD;
              cs      <= 1'b0;
              sh      <= {QSPI_CMD_QOR, bus.iomem_addr[23:2], 2'b00};
              bit_cnt <= '0;
            end
          end
        end
        ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA: begin
          if (sck_rise && (state == ST_DATA))
            nib <= {nib[27:0], qspi_io_i};
          // Command and address share one shift register; it advances on sck fall.
          if (sck_fall) begin
            sh <= {sh[30:0], 1'b0};
            if (bit_cnt == phase_last) begin
              bit_cnt <= '0;
              case (state)
                ST_CMD:   state <= ST_ADDR;
                ST_ADDR:  state <= ST_DUMMY;
                ST_DUMMY: state <= ST_DATA;
                default: begin
                  state <= ST_DONE;
                  cs    <= 1'b1;
                  ready <= 1'b1;
                  rdata <= bswap32(nib);
                end
              endcase
            end else begin
              bit_cnt <= bit_cnt + 8'd1;
            end
          end
        end
        ST_DONE: begin
          state   <= ST_GAP;
          gap_cnt <= '0;
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) state <= ST_IDLE;
          else                     gap_cnt <= gap_cnt + 16'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign drive_io0       = (state == ST_CMD) || (state == ST_ADDR);
  assign spi_cs_o        = cs;
  assign spi_sck_o       = sck;
  assign qspi_io_o       = {3'b000, sh[31] & drive_io0};
  assign qspi_io_oe      = drive_io0 ? 4'b0001 : 4'b0000;
  assign bus.iomem_ready = ready;
  assign bus.iomem_rdata = rdata;
  assign state_dbg       = qspi_state_e'(state);
endmodule

// File: tb/tb_qspi_flash_okuyucu.sv
// Bench for qspi_flash_okuyucu: two instances (default and slow SCK) against
// a behavioural quad-output flash model and a word-level read reference.
module tb_qspi_flash_okuyucu;
  import qspi_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [2];
  logic        valid [2];
  logic [3:0]  wstrb [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        ready [2];
  logic [31:0] rdata [2];
  logic        cs    [2];
  logic        sck   [2];
  logic [3:0]  io_o  [2];
  logic [3:0]  io_oe [2];
  logic [3:0]  io_i  [2];
  qspi_state_e st    [2];

  int          f_bits   [2];
  int          f_falls  [2];
  int          f_period [2];
  logic [7:0]  f_cmd    [2];
  logic [23:0] f_addr   [2];

  logic [7:0] mem [int];

  int n_tests = 0;
  int n_fail  = 0;

  function automatic int div_of(input int g);
    return (g == 0) ? 1 : 3;
  endfunction

  function automatic int dum_of(input int g);
    return (g == 0) ? 8 : 6;
  endfunction

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    int key;
    key = int'({8'h00, a});
    return mem.exists(key) ? mem[key] : 8'h00;
  endfunction

  // Reference: little-endian word at the word-aligned flash address.
  function automatic logic [31:0] exp_word(input logic [31:0] a);
    logic [23:0] w;
    w = {a[23:2], 2'b00};
    return {mem_byte(w + 24'd3), mem_byte(w + 24'd2), mem_byte(w + 24'd1), mem_byte(w)};
  endfunction

  // ---------------- DUTs and flash models ----------------
  for (genvar g = 0; g < 2; g++) begin : u
    localparam int DIV = (g == 0) ? 1 : 3;
    localparam int DUM = (g == 0) ? 8 : 6;

    qspi_flash_okuyucu_if bus ();

    int          bits = 0;
    int          falls = 0;
    int          per = 0;
    logic [7:0]  cmd_sh = '0;
    logic [23:0] addr_sh = '0;
    logic [3:0]  drv = '0;
    time         last_rise = 0;

    assign bus.iomem_valid = valid[g];
    assign bus.iomem_wstrb = wstrb[g];
    assign bus.iomem_addr  = addr[g];
    assign bus.iomem_wdata = wdata[g];
    assign ready[g]    = bus.iomem_ready;
    assign rdata[g]    = bus.iomem_rdata;
    assign io_i[g]     = drv;
    assign f_bits[g]   = bits;
    assign f_falls[g]  = falls;
    assign f_period[g] = per;
    assign f_cmd[g]    = cmd_sh;
    assign f_addr[g]   = addr_sh;

    qspi_flash_okuyucu #(.CLK_DIV(DIV), .DUMMY_CYC(DUM)) dut (
      .clk        (clk),
      .reset      (rst[g]),
      .bus        (bus.slave),
      .spi_cs_o   (cs[g]),
      .spi_sck_o  (sck[g]),
      .qspi_io_o  (io_o[g]),
      .qspi_io_oe (io_oe[g]),
      .qspi_io_i  (io_i[g]),
      .state_dbg  (st[g])
    );

    always @(negedge cs[g]) begin
      bits = 0;
      falls++;
    end

    always @(posedge sck[g]) begin
      if (!cs[g]) begin
        if (bits < 8)       cmd_sh  = {cmd_sh[6:0], io_o[g][0]};
        else if (bits < 32) addr_sh = {addr_sh[22:0], io_o[g][0]};
        if (bits > 0) per = int'(($time - last_rise) / 10);
        last_rise = $time;
        bits++;
      end
    end

    // Flash drives the next data nibble after each falling sck edge.
    always @(negedge sck[g] or posedge cs[g]) begin
      int k;
      logic [7:0] b;
      if (cs[g]) begin
        drv = '0;
      end else begin
        k = bits - 32 - DUM;
        if (k >= 0 && k < 8) begin
          b = mem_byte(addr_sh + 24'(k / 2));
          drv = (k % 2 == 0) ? b[7:4] : b[3:0];
        end
      end
    end
  end

  // ---------------- checking / driver tasks ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input int g, input string tag);
    chk({tag, " cs"},    32'(cs[g]), 32'd1);
    chk({tag, " sck"},   32'(sck[g]), 32'd0);
    chk({tag, " oe"},    32'(io_oe[g]), 32'd0);
    chk({tag, " ready"}, 32'(ready[g]), 32'd0);
  endtask

  // Issue one request and wait (bounded) for ready; lat = -1 on timeout.
  task automatic do_req(input int g, input logic [31:0] a, input logic [3:0] ws,
                        output logic [31:0] rd, output int lat);
    @(negedge clk);
    valid[g] = 1'b1;
    addr[g]  = a;
    wstrb[g] = ws;
    wdata[g] = $urandom;
    lat = -1;
    rd  = 'x;
    @(posedge clk);
    for (int k = 1; k <= 2000; k++) begin
      @(negedge clk);
      if (ready[g]) begin
        lat = k;
        rd  = rdata[g];
        break;
      end
    end
    valid[g] = 1'b0;
  endtask

  task automatic read_check(input int g, input logic [31:0] a, input string tag);
    logic [31:0] rd, exp;
    int lat, falls0, n;
    exp    = exp_word(a);
    n      = 40 + dum_of(g);
    falls0 = f_falls[g];
    do_req(g, a, 4'h0, rd, lat);
    chk({tag, " latency"}, 32'(lat), 32'(1 + 2 * div_of(g) * n));
    chk({tag, " rdata"},   rd, exp);
    chk({tag, " cmd"},     32'(f_cmd[g]), 32'h6B);
    chk({tag, " addr"},    32'(f_addr[g]), {8'h00, a[23:2], 2'b00});
    chk({tag, " sck cnt"}, 32'(f_bits[g]), 32'(n));
    chk({tag, " cs falls"}, 32'(f_falls[g]), 32'(falls0 + 1));
    @(negedge clk);
    chk({tag, " rdata clr"}, rdata[g], 32'h0);
    chk({tag, " ready clr"}, 32'(ready[g]), 32'd0);
    repeat (2 * div_of(g) + 2) @(negedge clk);
  endtask

  task automatic write_check(input int g, input logic [31:0] a, input logic [3:0] ws, input string tag);
    logic [31:0] rd;
    int lat, falls0;
    falls0 = f_falls[g];
    do_req(g, a, ws, rd, lat);
    chk({tag, " latency"}, 32'(lat), 32'd1);
    chk({tag, " rdata"},   rd, 32'h0);
    repeat (2 * div_of(g) + 2) @(negedge clk);
    chk({tag, " no cs"},   32'(f_falls[g]), 32'(falls0));
  endtask

  task automatic fill_word(input logic [31:0] a);
    logic [23:0] w;
    w = {a[23:2], 2'b00};
    for (int j = 0; j < 4; j++) mem[int'({8'h00, w + 24'(j)})] = 8'($urandom);
  endtask

  task automatic b2b_check(input int g, input logic [31:0] a1, input logic [31:0] a2, input string tag);
    int cnt;
    bit seen;
    @(negedge clk);
    valid[g] = 1'b1;
    wstrb[g] = 4'h0;
    addr[g]  = a1;
    seen = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (ready[g]) begin seen = 1'b1; break; end
    end
    chk({tag, " first ready"}, 32'(seen), 32'd1);
    chk({tag, " first rdata"}, rdata[g], exp_word(a1));
    addr[g] = a2;
    cnt = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      cnt++;
      if (!cs[g]) break;
    end
    chk({tag, " gap"}, 32'(cnt >= 2 * div_of(g) + 2), 32'd1);
    seen = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (ready[g]) begin seen = 1'b1; break; end
    end
    chk({tag, " second ready"}, 32'(seen), 32'd1);
    chk({tag, " second rdata"}, rdata[g], exp_word(a2));
    chk({tag, " second addr"},  32'(f_addr[g]), {8'h00, a2[23:2], 2'b00});
    valid[g] = 1'b0;
    repeat (2 * div_of(g) + 2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [31:0] a, a2;
    bit saw;
    for (int g = 0; g < 2; g++) begin
      rst[g] = 1'b1; valid[g] = 1'b0; wstrb[g] = '0; addr[g] = '0; wdata[g] = '0;
    end
    mem[int'(32'h000104)] = 8'h11; mem[int'(32'h000105)] = 8'h22;
    mem[int'(32'h000106)] = 8'h33; mem[int'(32'h000107)] = 8'h44;
    mem[int'(32'hFFFFFC)] = 8'hAA; mem[int'(32'hFFFFFD)] = 8'hBB;
    mem[int'(32'hFFFFFE)] = 8'hCC; mem[int'(32'hFFFFFF)] = 8'hDD;

    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk_reset_outputs(g, "por");
      chk("por rdata", rdata[g], 32'h0);
      chk("por state", 32'(st[g]), 32'd0);
    end
    rst[0] = 1'b0; rst[1] = 1'b0;
    repeat (2) @(negedge clk);

    // Asynchronous reset while sck is high in the command phase.
    valid[0] = 1'b1; wstrb[0] = 4'h0; addr[0] = 32'h3000_0106;
    saw = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (!cs[0] && sck[0]) begin saw = 1'b1; break; end
    end
    chk("async pre sck high", 32'(saw), 32'd1);
    valid[0] = 1'b0;
    #1 rst[0] = 1'b1;
    #1 chk_reset_outputs(0, "async rst");
    @(negedge clk);
    rst[0] = 1'b0;
    repeat (3) @(negedge clk);

    read_check(0, 32'h3000_0106, "basic");
    read_check(1, 32'h00FF_FFFC, "slow");
    chk("slow sck period", 32'(f_period[1]), 32'd6);
    write_check(0, 32'h0000_0010, 4'hF, "write");

    // Reset after the third data nibble has been sampled.
    @(negedge clk);
    valid[0] = 1'b1; wstrb[0] = 4'h0; addr[0] = 32'h0000_0104;
    saw = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (f_bits[0] == 40 + 3 && !cs[0]) begin saw = 1'b1; break; end
    end
    chk("data rst reached", 32'(saw), 32'd1);
    valid[0] = 1'b0;
    #1 rst[0] = 1'b1;
    #1 chk("data rst cs", 32'(cs[0]), 32'd1);
    repeat (2) @(negedge clk);
    rst[0] = 1'b0;
    saw = 1'b0;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      if (ready[0]) saw = 1'b1;
    end
    chk("data rst no ready", 32'(saw), 32'd0);
    read_check(0, 32'h0000_0104, "after rst");

    for (int g = 0; g < 2; g++) begin
      a  = $urandom; fill_word(a);
      a2 = $urandom; fill_word(a2);
      b2b_check(g, a, a2, "b2b");
    end

    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < 2; g++) begin
        a = $urandom;
        fill_word(a);
        read_check(g, a, "rand rd");
      end
    end
    for (int g = 0; g < 2; g++)
      write_check(g, $urandom, 4'($urandom_range(1, 15)), "rand wr");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
